// File: rtl/rtc_pkg.sv
// Shared encodings for the RTC bus scheduler: FSM states, burst IDs,
// RTC register map, init constants and write-data selectors.
package rtc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_GRANT = 4'd1,
    ST_ISSUE = 4'd2,
    ST_WAIT  = 4'd3,
    ST_NEXT  = 4'd4,
    ST_DONE  = 4'd5
  } state_t;

  typedef enum logic [1:0] {
    BURST_INIT = 2'd0,
    BURST_WCLK = 2'd1,
    BURST_WTMR = 2'd2,
    BURST_READ = 2'd3
  } burst_t;

  // Where the write byte of the current transaction comes from.
  typedef enum logic [3:0] {
    DSEL_INIT0 = 4'd0,
    DSEL_INIT1 = 4'd1,
    DSEL_INIT2 = 4'd2,
    DSEL_CLK0  = 4'd3,
    DSEL_CLK1  = 4'd4,
    DSEL_CLK2  = 4'd5,
    DSEL_CLK3  = 4'd6,
    DSEL_CLK4  = 4'd7,
    DSEL_CLK5  = 4'd8,
    DSEL_TMR0  = 4'd9,
    DSEL_TMR1  = 4'd10,
    DSEL_TMR2  = 4'd11,
    DSEL_NONE  = 4'd15
  } dsel_t;

  localparam logic [7:0] ADDR_SEG   = 8'h00;
  localparam logic [7:0] ADDR_MIN   = 8'h01;
  localparam logic [7:0] ADDR_HORA  = 8'h02;
  localparam logic [7:0] ADDR_DIA   = 8'h04;
  localparam logic [7:0] ADDR_MES   = 8'h05;
  localparam logic [7:0] ADDR_ANNO  = 8'h06;
  localparam logic [7:0] ADDR_TSEG  = 8'h08;
  localparam logic [7:0] ADDR_TMIN  = 8'h09;
  localparam logic [7:0] ADDR_THORA = 8'h0A;
  localparam logic [7:0] ADDR_CTRL  = 8'h0E;
  localparam logic [7:0] ADDR_CFG   = 8'h0F;

  localparam logic [7:0] INIT_CTRL_RST = 8'h10;
  localparam logic [7:0] INIT_CTRL_RUN = 8'h00;
  localparam logic [7:0] INIT_CFG      = 8'hD2;

  localparam logic [47:0] RD_TIME_RST = 48'h01_01_00_00_00_00;

endpackage

// File: rtl/rtc_burst_rom.sv
// Combinational burst table: (burst, index) -> register address, direction,
// write-data source and last-transaction flag.
module rtc_burst_rom import rtc_pkg::*; (
  input  burst_t      burst_id,
  input  logic [3:0]  idx,
  output logic [7:0]  addr,
  output logic        is_write,
  output dsel_t       data_sel,
  output logic        last
);

  always_comb begin
    addr     = 8'h00;
    is_write = 1'b0;
    data_sel = DSEL_NONE;
    last     = 1'b0;
    case (burst_id)
      BURST_INIT: begin
        is_write = 1'b1;
        last     = (idx == 4'd2);
        case (idx)
          4'd0:    begin addr = ADDR_CTRL; data_sel = DSEL_INIT0; end
          4'd1:    begin addr = ADDR_CTRL; data_sel = DSEL_INIT1; end
          default: begin addr = ADDR_CFG;  data_sel = DSEL_INIT2; end
        endcase
      end
      BURST_WCLK: begin
        is_write = 1'b1;
        last     = (idx == 4'd5);
        case (idx)
          4'd0:    begin addr = ADDR_DIA;  data_sel = DSEL_CLK0; end
          4'd1:    begin addr = ADDR_MES;  data_sel = DSEL_CLK1; end
          4'd2:    begin addr = ADDR_ANNO; data_sel = DSEL_CLK2; end
          4'd3:    begin addr = ADDR_HORA; data_sel = DSEL_CLK3; end
          4'd4:    begin addr = ADDR_MIN;  data_sel = DSEL_CLK4; end
          default: begin addr = ADDR_SEG;  data_sel = DSEL_CLK5; end
        endcase
      end
      BURST_WTMR: begin
        is_write = 1'b1;
        last     = (idx == 4'd2);
        case (idx)
          4'd0:    begin addr = ADDR_THORA; data_sel = DSEL_TMR0; end
          4'd1:    begin addr = ADDR_TMIN;  data_sel = DSEL_TMR1; end
          default: begin addr = ADDR_TSEG;  data_sel = DSEL_TMR2; end
        endcase
      end
      default: begin
        // Read order matches the shadow layout: six time registers, then timer.
        last = (idx == 4'd8);
        case (idx)
          4'd0:    addr = ADDR_DIA;
          4'd1:    addr = ADDR_MES;
          4'd2:    addr = ADDR_ANNO;
          4'd3:    addr = ADDR_HORA;
          4'd4:    addr = ADDR_MIN;
          4'd5:    addr = ADDR_SEG;
          4'd6:    addr = ADDR_THORA;
          4'd7:    addr = ADDR_TMIN;
          default: addr = ADDR_TSEG;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Owns the RTC chip bus: arbitrates init / date-time commit / timer commit /
// periodic read-back requests and runs each as a fixed register burst.
module rtc_bus_scheduler import rtc_pkg::*; #(
  parameter int unsigned REFRESH_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_req,
  input  logic        wr_clk_req,
  input  logic        wr_tmr_req,
  input  logic [47:0] clk_set,
  input  logic [23:0] tmr_set,
  output logic        cyc_start,
  output logic        cyc_wr,
  output logic [7:0]  cyc_addr,
  output logic [7:0]  cyc_wdata,
  input  logic        cyc_done,
  input  logic [7:0]  cyc_rdata,
  output logic [47:0] rd_time,
  output logic [23:0] rd_tmr,
  output logic        rd_valid,
  output logic        busy,
  output logic        err,
  output logic [3:0]  state
);

  // Bus handshake: cyc_start pulses once per transaction (ISSUE); cyc_wr,
  // cyc_addr and cyc_wdata hold from ISSUE through the cycle cyc_done is seen
  // in WAIT; cyc_done arriving in any other state is ignored.
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t      st_q, st_d;
  burst_t      burst_q, burst_sel;
  logic [3:0]  idx_q;
  logic        init_pend, clk_pend, tmr_pend, rd_pend, any_pend;
  logic [RW-1:0] ref_cnt;
  logic        ref_tc;
  logic [TW-1:0] tmo_cnt;
  logic        tmo_hit, grant, active;
  logic [47:0] clk_lat;
  logic [23:0] tmr_lat;
  logic [7:0]  shadow [9];
  logic [47:0] rd_time_q;
  logic [23:0] rd_tmr_q;
  logic        rd_valid_q, err_q;
  logic [7:0]  rom_addr, wdata_mux;
  logic        rom_wr, rom_last;
  dsel_t       rom_dsel;

  rtc_burst_rom u_rom (
    .burst_id (burst_q),
    .idx      (idx_q),
    .addr     (rom_addr),
    .is_write (rom_wr),
    .data_sel (rom_dsel),
    .last     (rom_last)
  );

  assign any_pend = init_pend | clk_pend | tmr_pend | rd_pend;
  assign grant    = (st_q == ST_GRANT);
  assign ref_tc   = (ref_cnt == RW'(REFRESH_CYCLES - 1));
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    burst_sel = BURST_READ;
    if (init_pend)     burst_sel = BURST_INIT;
    else if (clk_pend) burst_sel = BURST_WCLK;
    else if (tmr_pend) burst_sel = BURST_WTMR;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (any_pend) st_d = ST_GRANT;
      ST_GRANT: st_d = ST_ISSUE;
      ST_ISSUE: st_d = ST_WAIT;
      ST_WAIT: begin
        if (cyc_done)     st_d = ST_NEXT;
        else if (tmo_hit) st_d = ST_IDLE;
      end
      ST_NEXT:  st_d = rom_last ? ST_DONE : ST_ISSUE;
      ST_DONE:  st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wdata_mux = 8'h00;
    case (rom_dsel)
      DSEL_INIT0: wdata_mux = INIT_CTRL_RST;
      DSEL_INIT1: wdata_mux = INIT_CTRL_RUN;
      DSEL_INIT2: wdata_mux = INIT_CFG;
      DSEL_CLK0:  wdata_mux = clk_lat[47:40];
      DSEL_CLK1:  wdata_mux = clk_lat[39:32];
      DSEL_CLK2:  wdata_mux = clk_lat[31:24];
      DSEL_CLK3:  wdata_mux = clk_lat[23:16];
      DSEL_CLK4:  wdata_mux = clk_lat[15:8];
      DSEL_CLK5:  wdata_mux = clk_lat[7:0];
      DSEL_TMR0:  wdata_mux = tmr_lat[23:16];
      DSEL_TMR1:  wdata_mux = tmr_lat[15:8];
      DSEL_TMR2:  wdata_mux = tmr_lat[7:0];
      default:    wdata_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= ST_IDLE;
      burst_q    <= BURST_INIT;
      idx_q      <= '0;
      init_pend  <= 1'b0;
      clk_pend   <= 1'b0;
      tmr_pend   <= 1'b0;
      rd_pend    <= 1'b0;
      ref_cnt    <= '0;
      tmo_cnt    <= '0;
      clk_lat    <= '0;
      tmr_lat    <= '0;
      rd_time_q  <= RD_TIME_RST;
      rd_tmr_q   <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < 9; i++) shadow[i] <= 8'h00;
    end else begin
      st_q    <= st_d;
      ref_cnt <= ref_tc ? '0 : ref_cnt + 1'b1;
      // A request arriving during GRANT survives the clear for the next round.
      init_pend <= init_req   | (init_pend & ~(grant && burst_sel == BURST_INIT));
      clk_pend  <= wr_clk_req | (clk_pend  & ~(grant && burst_sel == BURST_WCLK));
      tmr_pend  <= wr_tmr_req | (tmr_pend  & ~(grant && burst_sel == BURST_WTMR));
      rd_pend   <= ref_tc     | (rd_pend   & ~(grant && burst_sel == BURST_READ));
      if (grant) begin
        burst_q <= burst_sel;
        idx_q   <= '0;
        clk_lat <= clk_set;
        tmr_lat <= tmr_set;
      end
      if (st_q == ST_NEXT && !rom_last) idx_q <= idx_q + 4'd1;
      if (st_q == ST_ISSUE)     tmo_cnt <= '0;
      else if (st_q == ST_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (st_q == ST_WAIT && cyc_done && burst_q == BURST_READ)
        shadow[idx_q] <= cyc_rdata;
      err_q      <= (st_q == ST_WAIT) && !cyc_done && tmo_hit;
      rd_valid_q <= (st_q == ST_DONE) && (burst_q == BURST_READ);
      if (st_q == ST_DONE && burst_q == BURST_READ) begin
        rd_time_q <= {shadow[0], shadow[1], shadow[2], shadow[3], shadow[4], shadow[5]};
        rd_tmr_q  <= {shadow[6], shadow[7], shadow[8]};
      end
    end
  end

  assign active    = (st_q == ST_ISSUE) || (st_q == ST_WAIT);
  assign cyc_start = (st_q == ST_ISSUE);
  assign cyc_wr    = active && rom_wr;
  assign cyc_addr  = active ? rom_addr : 8'h00;
  assign cyc_wdata = (active && rom_wr) ? wdata_mux : 8'h00;
  assign rd_time   = rd_time_q;
  assign rd_tmr    = rd_tmr_q;
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;
  assign busy      = (st_q != ST_IDLE);
  assign state     = st_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler: bus-engine responder, transaction-level model
// with per-cycle compare, and directed scenarios with literal expectations.
module tb_rtc_bus_scheduler;
  import rtc_pkg::*;

  localparam int REFRESH = 3000;
  localparam int TMO     = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_req = 1'b0, wr_clk_req = 1'b0, wr_tmr_req = 1'b0;
  logic [47:0] clk_set = '0;
  logic [23:0] tmr_set = '0;
  logic        cyc_start, cyc_wr;
  logic [7:0]  cyc_addr, cyc_wdata;
  logic        cyc_done = 1'b0;
  logic [7:0]  cyc_rdata = 8'h00;
  logic [47:0] rd_time;
  logic [23:0] rd_tmr;
  logic        rd_valid, busy, err;
  logic [3:0]  state;

  int total = 0;
  int bad   = 0;

  rtc_bus_scheduler #(.REFRESH_CYCLES(REFRESH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .init_req(init_req), .wr_clk_req(wr_clk_req),
    .wr_tmr_req(wr_tmr_req), .clk_set(clk_set), .tmr_set(tmr_set),
    .cyc_start(cyc_start), .cyc_wr(cyc_wr), .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
    .cyc_done(cyc_done), .cyc_rdata(cyc_rdata), .rd_time(rd_time), .rd_tmr(rd_tmr),
    .rd_valid(rd_valid), .busy(busy), .err(err), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- bus-engine responder ----------------
  logic [7:0] rd_by_addr [256];
  bit         hold_done = 1'b0;
  logic [7:0] rsp_a;
  int         rsp_d;
  int         rsp_n = 0;

  always begin
    @(posedge clk); #1;
    if (reset && cyc_start && !hold_done) begin
      rsp_a = cyc_addr;
      rsp_d = rsp_n % 3;
      rsp_n++;
      @(posedge clk); #1;
      repeat (rsp_d) begin @(posedge clk); #1; end
      cyc_done  = 1'b1;
      cyc_rdata = rd_by_addr[rsp_a];
      @(posedge clk); #1;
      cyc_done  = 1'b0;
      cyc_rdata = 8'h00;
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [16:0] exp_q[$];
  logic [16:0] log_q[$];
  logic [7:0]  m_rbytes[$];
  logic [16:0] m_e;
  bit   m_init, m_clk, m_tmr, m_rd, m_busy_prev, m_out, m_in_read, m_rd_ready;
  int   m_cnt, m_out_age;
  logic [47:0] m_exp_time;
  logic [23:0] m_exp_tmr;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete(); m_rbytes.delete();
      m_init = 0; m_clk = 0; m_tmr = 0; m_rd = 0; m_busy_prev = 0;
      m_out = 0; m_in_read = 0; m_rd_ready = 0; m_cnt = 0; m_out_age = 0;
      check("rst_busy", busy, 1'b0);
      check("rst_cyc_start", cyc_start, 1'b0);
      check("rst_state", state, ST_IDLE);
      check("rst_rd_time", rd_time, 48'h010100000000);
    end else begin
      if (busy && !m_busy_prev) begin
        check("grant_state", state, ST_GRANT);
        check("grant_has_pend", {m_init, m_clk, m_tmr, m_rd} != 4'b0, 1'b1);
        if (m_init) begin
          m_init = 0;
          exp_q.push_back({1'b1, ADDR_CTRL, 8'h10});
          exp_q.push_back({1'b1, ADDR_CTRL, 8'h00});
          exp_q.push_back({1'b1, ADDR_CFG,  8'hD2});
        end else if (m_clk) begin
          m_clk = 0;
          exp_q.push_back({1'b1, ADDR_DIA,  clk_set[47:40]});
          exp_q.push_back({1'b1, ADDR_MES,  clk_set[39:32]});
          exp_q.push_back({1'b1, ADDR_ANNO, clk_set[31:24]});
          exp_q.push_back({1'b1, ADDR_HORA, clk_set[23:16]});
          exp_q.push_back({1'b1, ADDR_MIN,  clk_set[15:8]});
          exp_q.push_back({1'b1, ADDR_SEG,  clk_set[7:0]});
        end else if (m_tmr) begin
          m_tmr = 0;
          exp_q.push_back({1'b1, ADDR_THORA, tmr_set[23:16]});
          exp_q.push_back({1'b1, ADDR_TMIN,  tmr_set[15:8]});
          exp_q.push_back({1'b1, ADDR_TSEG,  tmr_set[7:0]});
        end else if (m_rd) begin
          m_rd = 0; m_in_read = 1; m_rbytes.delete();
          exp_q.push_back({1'b0, ADDR_DIA,   8'h00});
          exp_q.push_back({1'b0, ADDR_MES,   8'h00});
          exp_q.push_back({1'b0, ADDR_ANNO,  8'h00});
          exp_q.push_back({1'b0, ADDR_HORA,  8'h00});
          exp_q.push_back({1'b0, ADDR_MIN,   8'h00});
          exp_q.push_back({1'b0, ADDR_SEG,   8'h00});
          exp_q.push_back({1'b0, ADDR_THORA, 8'h00});
          exp_q.push_back({1'b0, ADDR_TMIN,  8'h00});
          exp_q.push_back({1'b0, ADDR_TSEG,  8'h00});
        end
      end
      if (err) begin
        check("err_expected", {m_out, hold_done}, 2'b11);
        m_out = 0; m_in_read = 0; exp_q.delete(); m_rbytes.delete();
      end
      if (cyc_start) begin
        log_q.push_back({cyc_wr, cyc_addr, cyc_wdata});
        check("start_while_outstanding", m_out, 1'b0);
        check("txn_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          m_e = exp_q.pop_front();
          check("txn_wr", cyc_wr, m_e[16]);
          check("txn_addr", cyc_addr, m_e[15:8]);
          if (m_e[16]) check("txn_wdata", cyc_wdata, m_e[7:0]);
        end
        m_out = 1; m_out_age = 0;
      end else if (m_out) begin
        m_out_age++;
        check("hold_wr", cyc_wr, m_e[16]);
        check("hold_addr", cyc_addr, m_e[15:8]);
        if (cyc_done) begin
          m_out = 0;
          if (m_in_read) begin
            m_rbytes.push_back(cyc_rdata);
            if (m_rbytes.size() == 9) begin
              m_rd_ready = 1;
              m_exp_time = {m_rbytes[0], m_rbytes[1], m_rbytes[2], m_rbytes[3], m_rbytes[4], m_rbytes[5]};
              m_exp_tmr  = {m_rbytes[6], m_rbytes[7], m_rbytes[8]};
            end
          end
        end else if (m_out_age > TMO + 10) begin
          check("bus_progress", m_out_age <= TMO + 10, 1'b1);
          m_out = 0;
        end
      end
      if (rd_valid) begin
        check("rd_valid_expected", m_rd_ready, 1'b1);
        if (m_rd_ready) begin
          check("rd_time_model", rd_time, m_exp_time);
          check("rd_tmr_model", rd_tmr, m_exp_tmr);
        end
        m_rd_ready = 0; m_in_read = 0;
      end
      if (!busy && m_busy_prev) begin
        check("burst_drained", exp_q.size(), 0);
        check("burst_no_outstanding", m_out, 1'b0);
        check("rd_valid_on_time", m_rd_ready, 1'b0);
      end
      if (!busy) check("idle_state", state, ST_IDLE);
      if (init_req)   m_init = 1;
      if (wr_clk_req) m_clk = 1;
      if (wr_tmr_req) m_tmr = 1;
      if (m_cnt == REFRESH - 1) begin m_rd = 1; m_cnt = 0; end
      else m_cnt++;
      m_busy_prev = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n = 0;
    while (busy !== lvl && n < budget) begin tick(); n++; end
    check(name, busy, lvl);
  endtask

  task automatic wait_rd_valid(input int budget, input string name);
    int n = 0;
    while (rd_valid !== 1'b1 && n < budget) begin tick(); n++; end
    check(name, rd_valid, 1'b1);
  endtask

  task automatic wait_read_start(input int budget, input string name);
    int n = 0;
    while (!(cyc_start === 1'b1 && cyc_wr === 1'b0) && n < budget) begin tick(); n++; end
    check(name, {cyc_start, cyc_wr}, 2'b10);
  endtask

  // ---------------- directed scenarios ----------------
  logic [16:0] exp_wclk [6];
  logic [16:0] exp_mix  [6];
  int n_cyc, n_pulse;

  initial begin
    for (int i = 0; i < 256; i++) rd_by_addr[i] = 8'(i) ^ 8'h5A;
    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // 1: reset asserted while a transaction waits for cyc_done
    hold_done = 1'b1;
    clk_set = 48'h010203040506;
    wr_clk_req = 1'b1; tick(); wr_clk_req = 1'b0;
    n_cyc = 0;
    while (state !== ST_WAIT && n_cyc < 10) begin tick(); n_cyc++; end
    check("t1_reached_wait", state, ST_WAIT);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("t1_state", state, ST_IDLE);
    check("t1_busy", busy, 1'b0);
    check("t1_cyc_start", cyc_start, 1'b0);
    check("t1_rd_time", rd_time, 48'h010100000000);
    check("t1_rd_tmr", rd_tmr, 24'h000000);
    tick(); tick();
    reset = 1'b1;
    hold_done = 1'b0;
    tick();

    // 2: date/time commit, input changed after latch must not matter
    exp_wclk[0] = {1'b1, ADDR_DIA,  8'h15};
    exp_wclk[1] = {1'b1, ADDR_MES,  8'h09};
    exp_wclk[2] = {1'b1, ADDR_ANNO, 8'h16};
    exp_wclk[3] = {1'b1, ADDR_HORA, 8'h14};
    exp_wclk[4] = {1'b1, ADDR_MIN,  8'h30};
    exp_wclk[5] = {1'b1, ADDR_SEG,  8'h00};
    log_q.delete();
    clk_set = 48'h150916143000;
    wr_clk_req = 1'b1; tick(); wr_clk_req = 1'b0;
    wait_busy(1'b1, 10, "t2_busy_rise");
    tick();
    clk_set = 48'hFFFFFFFFFFFF;
    wait_busy(1'b0, 200, "t2_busy_fall");
    check("t2_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < log_q.size()) check("t2_txn", log_q[i], exp_wclk[i]);

    // 3: init and timer requested together; init burst goes first
    exp_mix[0] = {1'b1, ADDR_CTRL,  8'h10};
    exp_mix[1] = {1'b1, ADDR_CTRL,  8'h00};
    exp_mix[2] = {1'b1, ADDR_CFG,   8'hD2};
    exp_mix[3] = {1'b1, ADDR_THORA, 8'h12};
    exp_mix[4] = {1'b1, ADDR_TMIN,  8'h34};
    exp_mix[5] = {1'b1, ADDR_TSEG,  8'h56};
    log_q.delete();
    tmr_set = 24'h123456;
    init_req = 1'b1; wr_tmr_req = 1'b1; tick(); init_req = 1'b0; wr_tmr_req = 1'b0;
    wait_busy(1'b1, 10, "t3_busy_rise_a");
    wait_busy(1'b0, 200, "t3_busy_fall_a");
    wait_busy(1'b1, 10, "t3_busy_rise_b");
    wait_busy(1'b0, 200, "t3_busy_fall_b");
    check("t3_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < log_q.size()) check("t3_txn", log_q[i], exp_mix[i]);

    // 4: refresh read returns a known snapshot exactly once
    rd_by_addr[ADDR_DIA]   = 8'h31;
    rd_by_addr[ADDR_MES]   = 8'h12;
    rd_by_addr[ADDR_ANNO]  = 8'h99;
    rd_by_addr[ADDR_HORA]  = 8'h23;
    rd_by_addr[ADDR_MIN]   = 8'h59;
    rd_by_addr[ADDR_SEG]   = 8'h59;
    rd_by_addr[ADDR_THORA] = 8'h01;
    rd_by_addr[ADDR_TMIN]  = 8'h02;
    rd_by_addr[ADDR_TSEG]  = 8'h03;
    wait_rd_valid(REFRESH + 500, "t4_rd_valid");
    check("t4_rd_time", rd_time, 48'h311299235959);
    check("t4_rd_tmr", rd_tmr, 24'h010203);
    n_pulse = 0;
    repeat (20) begin tick(); if (rd_valid) n_pulse++; end
    check("t4_single_pulse", n_pulse, 0);

    // 6: timer commit requested mid-read runs right after the read
    wait_read_start(REFRESH + 500, "t6_read_start");
    tmr_set = 24'h235959;
    wr_tmr_req = 1'b1; tick(); wr_tmr_req = 1'b0;
    wait_rd_valid(200, "t6_rd_valid");
    n_cyc = 0;
    while (cyc_start !== 1'b1 && n_cyc < 20) begin tick(); n_cyc++; end
    check("t6_next_start", cyc_start, 1'b1);
    check("t6_next_wr", cyc_wr, 1'b1);
    check("t6_next_addr", cyc_addr, ADDR_THORA);
    check("t6_next_wdata", cyc_wdata, 8'h23);
    wait_busy(1'b0, 200, "t6_busy_fall");

    // 5: cyc_done withheld during a read -> timeout error, snapshot kept
    hold_done = 1'b1;
    wait_read_start(REFRESH + 500, "t5_read_start");
    n_cyc = 0;
    while (err !== 1'b1 && n_cyc < 400) begin tick(); n_cyc++; end
    check("t5_err", err, 1'b1);
    check("t5_err_latency", (n_cyc >= TMO) && (n_cyc <= TMO + 3), 1'b1);
    check("t5_state", state, ST_IDLE);
    check("t5_busy", busy, 1'b0);
    check("t5_rd_time", rd_time, 48'h311299235959);
    check("t5_rd_tmr", rd_tmr, 24'h010203);
    tick();
    check("t5_err_pulse", err, 1'b0);
    hold_done = 1'b0;

    repeat (20) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected test end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
